// File: rtl/dmem_pkg.sv
// Shared types and helpers for the MEM-stage data-memory access unit.
`timescale 1ns/1ps
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // funct3[1:0] carries the access size for both signed and unsigned loads.
    function automatic logic [3:0] be_gen(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (funct3[1:0])
            2'b00:   be = 4'b0001 << addr_lo;
            2'b01:   be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dmem_access_unit_load_extend.sv
// Selects the addressed byte/half lane of a bus read word and sign- or zero-extends it.
`timescale 1ns/1ps
module load_extend
    import dmem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] result_o
);

    logic [7:0]  lanes [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lanes[gi] = rdata_i[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        byte_sel = lanes[offset_i];
        half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (funct3_i)
            F3_B:    result_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   result_o = {24'd0, byte_sel};
            F3_H:    result_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   result_o = {16'd0, half_sel};
            default: result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory access unit: turns RV32I loads/stores into byte-enabled
// word bus transactions, stalls until ack or timeout, and extends load data.
`timescale 1ns/1ps
module dmem_access_unit
    import dmem_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT_W  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [DM_ADDRESS-1:0] addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [2:0]            funct3,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  stall,
    output logic                  misaligned,
    output logic                  bus_err,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [DM_ADDRESS-3:0] bus_addr,
    output logic [3:0]            bus_be,
    output logic [DATA_W-1:0]     bus_wdata,
    input  logic                  bus_ack,
    input  logic [DATA_W-1:0]     bus_rdata
);

    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LIMIT = '1;

    state_t                state_q, state_d;
    logic [TIMEOUT_W-1:0]  cnt_q, cnt_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [3:0]            be_q, be_d;
    logic [DM_ADDRESS-3:0] baddr_q, baddr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W-1:0]     rd_q, rd_d;
    logic [2:0]            f3_q, f3_d;
    logic [1:0]            off_q, off_d;
    logic                  tout_q, tout_d;

    logic                  any_req, f3_legal, misal, req_err, req_misal, req_ok;
    logic [DATA_W-1:0]     wdata_rep;
    logic [DATA_W-1:0]     ext_data;

    load_extend u_load_extend (
        .rdata_i  (bus_rdata),
        .offset_i (off_q),
        .funct3_i (f3_q),
        .result_o (ext_data)
    );

    always_comb begin
        any_req   = mem_read | mem_write;
        f3_legal  = mem_write ? (funct3 inside {F3_B, F3_H, F3_W})
                              : (funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        misal     = ((funct3[1:0] == 2'b01) && addr[0]) ||
                    ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        req_err   = any_req && ((mem_read && mem_write) || !f3_legal);
        req_misal = any_req && !req_err && misal;
        req_ok    = any_req && !req_err && !misal;
        case (funct3[1:0])
            2'b00:   wdata_rep = {4{wr_data[7:0]}};
            2'b01:   wdata_rep = {2{wr_data[15:0]}};
            default: wdata_rep = wr_data;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        be_d       = be_q;
        baddr_d    = baddr_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        f3_d       = f3_q;
        off_d      = off_q;
        tout_d     = 1'b0;
        stall      = 1'b0;
        misaligned = 1'b0;
        bus_err    = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    rd_d       = '0;
                    bus_err    = req_err;
                    misaligned = req_misal;
                end
                if (req_ok) begin
                    stall   = 1'b1;
                    req_d   = 1'b1;
                    we_d    = mem_write;
                    be_d    = be_gen(funct3, addr[1:0]);
                    baddr_d = addr[DM_ADDRESS-1:2];
                    wdata_d = wdata_rep;
                    f3_d    = funct3;
                    off_d   = addr[1:0];
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (bus_ack) begin
                    req_d   = 1'b0;
                    rd_d    = we_q ? '0 : ext_data;
                    state_d = DONE;
                end else if (cnt_d == TIMEOUT_LIMIT) begin
                    req_d   = 1'b0;
                    rd_d    = '0;
                    tout_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                // Request inputs are still those of the finished access; never re-issue.
                bus_err = tout_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= '0;
            baddr_q <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            f3_q    <= '0;
            off_q   <= '0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            be_q    <= be_d;
            baddr_q <= baddr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            tout_q  <= tout_d;
        end
    end

    assign rd_data   = rd_q;
    assign bus_req   = req_q;
    assign bus_we    = we_q;
    assign bus_addr  = baddr_q;
    assign bus_be    = be_q;
    assign bus_wdata = wdata_q;

endmodule
